// File: rtl/sd_resp_rx_if.sv
// Controller <-> response-receiver handshake and parsed-status bundle.
interface sd_resp_rx_if;
  logic        rx_start;
  logic [1:0]  rx_mode;
  logic        rx_busy;
  logic        rx_done;
  logic [7:0]  resp_r1;
  logic [31:0] resp_ext;
  logic [2:0]  dresp_status;
  logic        dresp_ok;
  logic        rx_timeout;

  modport master (
    output rx_start, rx_mode,
    input  rx_busy, rx_done, resp_r1, resp_ext, dresp_status, dresp_ok, rx_timeout
  );

  modport slave (
    input  rx_start, rx_mode,
    output rx_busy, rx_done, resp_r1, resp_ext, dresp_status, dresp_ok, rx_timeout
  );
endinterface

// File: rtl/sd_resp_rx.sv
// SD SPI MISO response receiver: R1, R1+32b tail, data-response token, busy release.
// Optional wait/busy timeouts are compiled in with SD_RESP_TIMEOUT_EN.
module sd_resp_rx #(
  parameter int NCR_MAX   = 64,
  parameter int BUSY_MAX  = 250000,
  parameter int BUSY_ONES = 8
) (
  input  logic         clk_ref_180deg,
  input  logic         rst_n,
  input  logic         sd_miso,
  sd_resp_rx_if.slave  rx
);

  typedef enum logic [2:0] {
    IDLE, WAIT_START, RX_R1, RX_EXT, RX_DTOK, WAIT_BUSY
  } state_t;

  localparam logic [1:0] MODE_R1EXT = 2'd1;
  localparam logic [1:0] MODE_DTOK  = 2'd2;
  localparam logic [1:0] MODE_BUSY  = 2'd3;
  localparam int ONES_W = $clog2(BUSY_ONES + 1);

  if ((NCR_MAX < 1) || (BUSY_ONES < 1) || (BUSY_MAX < BUSY_ONES)) begin : g_bad_cfg
    $error("sd_resp_rx: invalid NCR_MAX/BUSY_MAX/BUSY_ONES");
  end

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [5:0]          bit_cnt_q;
  logic [ONES_W-1:0]   ones_cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [7:0]          r1_q;
  logic [31:0]         ext_q;
  logic [2:0]          dstat_q;
  logic                dok_q;
  logic [7:0]          r1_sh_q;
  logic [31:0]         ext_sh_q;
  logic [2:0]          tok_sh_q;

`ifdef SD_RESP_TIMEOUT_EN
  localparam int WAIT_W = $clog2(BUSY_MAX + 1);
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                timeout_q;
`endif

  always_ff @(posedge clk_ref_180deg or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'd0;
      bit_cnt_q  <= 6'd0;
      ones_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      r1_q       <= 8'hFF;
      ext_q      <= 32'd0;
      dstat_q    <= 3'b111;
      dok_q      <= 1'b0;
`ifdef SD_RESP_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx.rx_start) begin
            mode_q     <= rx.rx_mode;
            busy_q     <= 1'b1;
            dok_q      <= 1'b0;
            ones_cnt_q <= '0;
`ifdef SD_RESP_TIMEOUT_EN
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
`endif
            state_q    <= (rx.rx_mode == MODE_BUSY) ? WAIT_BUSY : WAIT_START;
          end
        end
        WAIT_START: begin
          if (!sd_miso) begin
            // In R1 modes the start bit doubles as R1 bit 7.
            if (mode_q == MODE_DTOK) begin
              state_q   <= RX_DTOK;
              bit_cnt_q <= 6'd0;
            end else begin
              state_q   <= RX_R1;
              bit_cnt_q <= 6'd1;
            end
          end
`ifdef SD_RESP_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_W'(NCR_MAX - 1)) begin
            timeout_q <= 1'b1;
            r1_q      <= 8'hFF;
            dok_q     <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        RX_R1: begin
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd7) begin
            if (mode_q == MODE_R1EXT) begin
              state_q   <= RX_EXT;
              bit_cnt_q <= 6'd0;
            end else begin
              r1_q    <= {r1_sh_q[6:0], sd_miso};
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        RX_EXT: begin
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd31) begin
            r1_q    <= r1_sh_q;
            ext_q   <= {ext_sh_q[30:0], sd_miso};
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RX_DTOK: begin
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd3) begin
            dstat_q <= tok_sh_q;
            dok_q   <= (tok_sh_q == 3'b010) && sd_miso;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        WAIT_BUSY: begin
          if (sd_miso && (ones_cnt_q == ONES_W'(BUSY_ONES - 1))) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
`ifdef SD_RESP_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_W'(BUSY_MAX - 1)) begin
            timeout_q <= 1'b1;
            r1_q      <= 8'hFF;
            dok_q     <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
`endif
          else begin
            ones_cnt_q <= sd_miso ? ones_cnt_q + 1'b1 : '0;
`ifdef SD_RESP_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Shift registers carry only in-flight data and are committed on completion.
  always_ff @(posedge clk_ref_180deg) begin
    if (((state_q == WAIT_START) && !sd_miso) || (state_q == RX_R1))
      r1_sh_q <= {r1_sh_q[6:0], sd_miso};
    if (state_q == RX_EXT)
      ext_sh_q <= {ext_sh_q[30:0], sd_miso};
    if (state_q == RX_DTOK)
      tok_sh_q <= {tok_sh_q[1:0], sd_miso};
  end

  assign rx.rx_busy      = busy_q;
  assign rx.rx_done      = done_q;
  assign rx.resp_r1      = r1_q;
  assign rx.resp_ext     = ext_q;
  assign rx.dresp_status = dstat_q;
  assign rx.dresp_ok     = dok_q;
`ifdef SD_RESP_TIMEOUT_EN
  assign rx.rx_timeout   = timeout_q;
`else
  assign rx.rx_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed bench for sd_resp_rx: each response type, busy wait, reset abort, optional timeout.
module tb_sd_resp_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sd_miso = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  sd_resp_rx_if rif();

  sd_resp_rx #(.NCR_MAX(64), .BUSY_MAX(250000), .BUSY_ONES(8)) dut (
    .clk_ref_180deg (clk),
    .rst_n          (rst_n),
    .sd_miso        (sd_miso),
    .rx             (rif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, rif.rx_busy, 0);
    chk({tag, "_done"}, rif.rx_done, 0);
    chk({tag, "_r1"},   rif.resp_r1, 32'hFF);
    chk({tag, "_ext"},  rif.resp_ext, 0);
    chk({tag, "_dst"},  rif.dresp_status, 3'b111);
    chk({tag, "_dok"},  rif.dresp_ok, 0);
    chk({tag, "_tmo"},  rif.rx_timeout, 0);
  endtask

  // Arm edge; MISO is driven low here to show it is not taken as a start bit.
  task automatic arm(input logic [1:0] m, input string tag);
    rif.rx_start = 1'b1;
    rif.rx_mode  = m;
    sd_miso      = 1'b0;
    tick();
    rif.rx_start = 1'b0;
    chk({tag, "_arm_busy"}, rif.rx_busy, 1);
    chk({tag, "_arm_done"}, rif.rx_done, 0);
  endtask

  task automatic bit_step(input logic b, input int idx, input int done_at, input string tag);
    sd_miso = b;
    tick();
    chk({tag, "_done"}, rif.rx_done, (idx == done_at) ? 1 : 0);
    chk({tag, "_busy"}, rif.rx_busy, (idx < done_at) ? 1 : 0);
  endtask

  task automatic run_vec(input logic [63:0] v, input int n, input int done_at, input string tag);
    for (int i = 0; i < n; i++) bit_step(v[n-1-i], i + 1, done_at, tag);
  endtask

  initial begin
    logic [63:0] vec;
    rif.rx_start = 1'b0;
    rif.rx_mode  = 2'd0;
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("post_rst");

    // R1: three idle ones, then 8'h00; done 11 edges after arm.
    arm(2'd0, "r1");
    vec = 64'b111_00000000;
    run_vec(vec, 11, 11, "r1");
    chk("r1_resp", rif.resp_r1, 8'h00);
    chk("r1_tmo",  rif.rx_timeout, 0);
    tick();
    chk("r1_done_1cyc", rif.rx_done, 0);

    // R1EXT: 8'h01 then 32'h000001AA, start bit on first edge -> 40 edges.
    arm(2'd1, "r1ext");
    vec = {24'd0, 8'h01, 32'h000001AA};
    run_vec(vec, 40, 40, "r1ext");
    chk("r1ext_r1",  rif.resp_r1, 8'h01);
    chk("r1ext_ext", rif.resp_ext, 32'h000001AA);

    // Re-arm in the done cycle: DTOK 1,1,1,0,0,1,0,1 -> status 010, ok.
    arm(2'd2, "dtok_a");
    vec = 64'b1110_0101;
    run_vec(vec, 8, 8, "dtok_a");
    chk("dtok_a_st", rif.dresp_status, 3'b010);
    chk("dtok_a_ok", rif.dresp_ok, 1);
    chk("dtok_a_r1hold", rif.resp_r1, 8'h01);
    tick();
    chk("dtok_a_done_1cyc", rif.rx_done, 0);

    // DTOK with sss=101, start bit immediately -> 5 edges.
    arm(2'd2, "dtok_b");
    vec = 64'b0_1011;
    run_vec(vec, 5, 5, "dtok_b");
    chk("dtok_b_st", rif.dresp_status, 3'b101);
    chk("dtok_b_ok", rif.dresp_ok, 0);
    chk("dtok_b_exthold", rif.resp_ext, 32'h000001AA);

    // BUSY: 1000 zeros, 1,1,1,0, eight ones; an rx_start mid-way is ignored.
    arm(2'd3, "busy");
    for (int i = 1; i <= 1000; i++) begin
      if (i == 500) begin
        rif.rx_start = 1'b1;
        rif.rx_mode  = 2'd0;
      end
      bit_step(1'b0, i, 1012, "busy");
      rif.rx_start = 1'b0;
    end
    vec = 64'b1110_11111111;
    for (int i = 0; i < 12; i++) bit_step(vec[11-i], 1001 + i, 1012, "busy_tail");
    chk("busy_tmo", rif.rx_timeout, 0);
    chk("busy_r1hold", rif.resp_r1, 8'h01);

    // Reset in the middle of RX_EXT.
    arm(2'd1, "abort");
    vec = {8'h01, 10'b1111111111};
    run_vec(vec, 18, 99, "abort");
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort_rst");
    tick();
    chk("abort_nodone", rif.rx_done, 0);
    rst_n = 1'b1;
    sd_miso = 1'b1;
    tick();
    chk("abort_idle_done", rif.rx_done, 0);
    chk("abort_idle_busy", rif.rx_busy, 0);

    // R1 after the abort: start bit then 1010101 -> 8'h55 in 8 edges.
    arm(2'd0, "r1_after");
    vec = 64'b0101_0101;
    run_vec(vec, 8, 8, "r1_after");
    chk("r1_after_resp", rif.resp_r1, 8'h55);
    chk("r1_after_ext",  rif.resp_ext, 0);

`ifdef SD_RESP_TIMEOUT_EN
    // No start bit: timeout after NCR_MAX edges; rx_start while busy ignored.
    arm(2'd0, "tmo");
    for (int i = 1; i <= 64; i++) begin
      if (i == 10) begin
        rif.rx_start = 1'b1;
        rif.rx_mode  = 2'd2;
      end
      bit_step(1'b1, i, 64, "tmo");
      rif.rx_start = 1'b0;
    end
    chk("tmo_flag", rif.rx_timeout, 1);
    chk("tmo_r1",   rif.resp_r1, 8'hFF);
    chk("tmo_dok",  rif.dresp_ok, 0);
    tick();
    chk("tmo_hold", rif.rx_timeout, 1);
    chk("tmo_done_1cyc", rif.rx_done, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sd_resp_rx.md
Name: sd_resp_rx

Overview:
- Serial response receiver on the SD SPI MISO line, used by the SD write path (and later the read and init paths).
- When armed by a controller, it captures one of four response types:
  - the R1 command response;
  - R1 plus a 32-bit tail (R3/R7);
  - the data-response token that follows a written block;
  - the card busy release.
- Runs on clk_ref_180deg so MISO is sampled on the SD clock rising edge.
- Delivers parsed status plus a one-cycle done strobe back to the controller.

Parameters:
- NCR_MAX, 64, maximum bit times from arming to a start bit (R1/R1EXT/DTOK modes).
- BUSY_MAX, 250000, maximum bit times in busy-wait mode before timeout.
- BUSY_ONES, 8, consecutive 1 bits on MISO that declare the card not busy.

Ports:
- clk_ref_180deg  input  1  sampling clock; rising edge = SD clock rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sd_miso  input  1  SD card serial output.
- rx_start  input  1  one-cycle arm pulse; ignored while rx_busy=1.
- rx_mode  input  2  0=R1, 1=R1EXT (R1 + 32 bits), 2=DTOK (data-response token), 3=BUSY; sampled with rx_start.
- rx_busy  output  1  high from the edge after rx_start until the rx_done edge.
- rx_done  output  1  one-cycle completion strobe.
- resp_r1  output  8  captured R1 byte, MSB first.
- resp_ext  output  32  captured 32-bit tail, MSB first (R1EXT only).
- dresp_status  output  3  token status bits sss.
- dresp_ok  output  1  token == 010 with valid end bit.
- rx_timeout  output  1  last operation timed out; valid while rx_done=1 and held until next rx_start.

Behaviour:
- Reset: state IDLE, all counters 0.
  - Output reset values: rx_busy=0, rx_done=0, resp_r1=8'hFF, resp_ext=0, dresp_status=3'b111, dresp_ok=0, rx_timeout=0.
- Reset mid-operation aborts immediately and no rx_done is produced.
- States: IDLE, WAIT_START, RX_R1, RX_EXT, RX_DTOK, WAIT_BUSY.
- IDLE:
  - On rx_start=1: latch rx_mode; clear rx_timeout, dresp_ok and wait counter; set rx_busy.
  - Next state is WAIT_BUSY for mode 3, otherwise WAIT_START.
  - The MISO value at the rx_start edge is not used.
- WAIT_START: each edge with sd_miso=0 is the start bit.
  - R1/R1EXT: the start bit is R1 bit 7 (stored as 0); go to RX_R1 with bit_cnt=1.
  - DTOK: the start bit is the token's 0 marker; go to RX_DTOK with bit_cnt=0.
  - sd_miso=1: increment wait counter.
- RX_R1: shift 7 more bits.
  - On the 8th bit: mode R1 → rx_done; mode R1EXT → RX_EXT, bit_cnt=0.
- RX_EXT: shift 32 bits into resp_ext; rx_done on the 32nd.
- RX_DTOK: shift 4 bits b3..b0.
  - dresp_status = b3..b1.
  - dresp_ok = (b3..b1==3'b010) && b0==1.
  - rx_done on the 4th bit.
- WAIT_BUSY:
  - Count consecutive 1 samples; any 0 resets the count.
  - When the count reaches BUSY_ONES, rx_done.
- rx_done timing:
  - rx_done is registered at the same edge that samples the final bit; resp_* update at that edge.
  - rx_busy drops at that edge; rx_done is high for exactly one cycle; state returns to IDLE.
  - The total time a completing operation occupies the receiver is its bit count.
- Latency examples:
  - R1 with a start bit on the first sampled edge: rx_done visible 8 edges after the rx_start edge.
  - R1EXT: 40 edges.
  - DTOK: 5 edges.
- resp_* hold their values until overwritten by the next operation of the same type.
- A new rx_start is accepted in the cycle rx_done is high, since the state is IDLE that cycle.
- Counter widths: bit_cnt 6 bits; wait counter wide enough for BUSY_MAX; no wrap is possible before timeout.

Optional Feature:
- Macro: SD_RESP_TIMEOUT_EN.
- Defined:
  - WAIT_START timeout: the wait counter reaching NCR_MAX with no start bit → rx_timeout=1, rx_done=1, resp_r1=8'hFF, dresp_ok=0, return to IDLE.
  - WAIT_BUSY timeout: the total bit counter reaching BUSY_MAX → same result.
- Not defined:
  - No timeout; the receiver waits indefinitely.
  - rx_timeout is tied to 0.
  - The wait counter logic is removed.

Test Plan:
- R1 mode, MISO=1 for 3 edges then byte 8'h00 → rx_done 11 edges after the arm edge, resp_r1=8'h00, rx_timeout=0, rx_busy high for exactly that window.
- R1EXT mode, MISO sends 8'h01 then 32'h000001AA → resp_r1=8'h01, resp_ext=32'h000001AA, single rx_done pulse.
- DTOK mode, MISO 1,1,1,0,0,1,0,1 → dresp_status=3'b010, dresp_ok=1. Repeat with sss=101 → dresp_status=3'b101, dresp_ok=0.
- BUSY mode, MISO 0 for 1000 edges, then 1,1,1,0, then eight 1s → rx_done on the 8th 1 of the final run, not earlier.
- SD_RESP_TIMEOUT_EN defined, R1 mode with MISO held 1 → rx_done and rx_timeout=1 after NCR_MAX=64 edges, resp_r1=8'hFF. rx_start pulsed while busy is ignored.
- Assert rst_n low mid-RX_EXT → all outputs at reset values, no rx_done. A subsequent R1 operation completes normally.
